// File: rtl/spi_readback_ctrl.sv
// SPI status-readback sequencer: freezes a tagged snapshot of the live status on each
// chip-select assertion, counts SPI bits and classifies each frame for the fabric.
module spi_readback_ctrl #(
    parameter int WIDTH   = 48,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_clk,
    input  logic             cs_n,
    input  logic             upd_valid,
    input  logic [WIDTH-9:0] upd_data,
    output logic [WIDTH-1:0] snapshot,
    output logic             busy,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [1:0]       err_code,
    output logic [7:0]       frame_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ABORT  = 2'd2
    } state_t;

    localparam logic [8:0]  BIT_TARGET = 9'(WIDTH);
    localparam logic [8:0]  BIT_MAX    = 9'd511;
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

    state_t           state;
    logic [2:0]       cs_sync;
    logic [2:0]       sck_sync;
    logic [WIDTH-9:0] live;
    logic [8:0]       bit_cnt;
    logic [15:0]      tmo_cnt;

    logic       cs_fall;
    logic       cs_rise;
    logic       sck_rise;
    logic [8:0] bit_next;

    // Chains reset to 0, so a cs_n held low through reset release never looks like a fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync  <= 3'b000;
            sck_sync <= 3'b000;
        end else begin
            // NOTE: every clocked register uses <= so all flops sample pre-edge values.
            cs_sync  <= {cs_sync[1:0], cs_n};
            sck_sync <= {sck_sync[1:0], spi_clk};
        end
    end

    // Bit index: [0] = s0, [1] = s1, [2] = s2.
    assign cs_fall  =  cs_sync[2]  & ~cs_sync[1];
    assign cs_rise  = ~cs_sync[2]  &  cs_sync[1];
    assign sck_rise = ~sck_sync[2] &  sck_sync[1];

    // An edge arriving with cs_rise is counted before the frame is classified.
    assign bit_next = (sck_rise && bit_cnt != BIT_MAX) ? bit_cnt + 9'd1 : bit_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live <= '0;
        end else if (upd_valid) begin
            live <= upd_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            snapshot  <= '0;
            busy      <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'b00;
            frame_cnt <= 8'd0;
            bit_cnt   <= 9'd0;
            tmo_cnt   <= 16'd0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        snapshot  <= {frame_cnt, (upd_valid ? upd_data : live)};
                        frame_cnt <= frame_cnt + 8'd1;
                        bit_cnt   <= 9'd0;
                        tmo_cnt   <= 16'd0;
                        busy      <= 1'b1;
                        state     <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    bit_cnt <= bit_next;
                    if (cs_rise) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                        if (bit_next == BIT_TARGET) begin
                            frame_ok <= 1'b1;
                            err_code <= 2'b00;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= (bit_next < BIT_TARGET) ? 2'b01 : 2'b10;
                        end
                    end else if (sck_rise) begin
                        tmo_cnt <= 16'd0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        frame_err <= 1'b1;
                        err_code  <= 2'b11;
                        state     <= ABORT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                ABORT: begin
                    if (cs_rise) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_readback_ctrl.sv
// Directed self-checking bench for spi_readback_ctrl (WIDTH 48, TIMEOUT 16).
module tb_spi_readback_ctrl;

    localparam int WIDTH   = 48;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             spi_clk;
    logic             cs_n;
    logic             upd_valid;
    logic [WIDTH-9:0] upd_data;
    logic [WIDTH-1:0] snapshot;
    logic             busy;
    logic             frame_ok;
    logic             frame_err;
    logic [1:0]       err_code;
    logic [7:0]       frame_cnt;

    int checks = 0;
    int errors = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int ok_base;
    int err_base;

    spi_readback_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .spi_clk   (spi_clk),
        .cs_n      (cs_n),
        .upd_valid (upd_valid),
        .upd_data  (upd_data),
        .snapshot  (snapshot),
        .busy      (busy),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_ok)  ok_cnt++;
        if (frame_err) err_cnt++;
        if (frame_ok && frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sck_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            spi_clk = 1'b1;
            wait_clk(2);
            spi_clk = 1'b0;
            wait_clk(2);
        end
    endtask

    task automatic run_frame(input int n);
        cs_n = 1'b0;
        wait_clk(6);
        sck_pulses(n);
        cs_n = 1'b1;
        wait_clk(6);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(5);
    endtask

    logic [WIDTH-1:0] held;

    initial begin
        reset     = 1'b1;
        spi_clk   = 1'b0;
        cs_n      = 1'b1;
        upd_valid = 1'b0;
        upd_data  = '0;
        wait_clk(3);
        check("rst_snapshot", 64'(snapshot), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'h0);
        check("rst_err_code", 64'(err_code), 64'h0);
        reset = 1'b0;
        wait_clk(5);
        check("rst_cs_rise_ignored", 64'(busy), 64'h0);

        // Good frame
        upd_valid = 1'b1;
        upd_data  = 40'h01AA55000F;
        wait_clk(1);
        upd_valid = 1'b0;
        ok_base  = ok_cnt;
        err_base = err_cnt;
        cs_n = 1'b0;
        wait_clk(4);
        check("good_busy_active", 64'(busy), 64'h1);
        check("good_snapshot", 64'(snapshot), 64'h0001AA55000F);
        wait_clk(2);
        sck_pulses(48);
        cs_n = 1'b1;
        wait_clk(6);
        check("good_ok_pulses", 64'(ok_cnt - ok_base), 64'd1);
        check("good_err_pulses", 64'(err_cnt - err_base), 64'd0);
        check("good_err_code", 64'(err_code), 64'h0);
        check("good_frame_cnt", 64'(frame_cnt), 64'd1);
        check("good_busy_end", 64'(busy), 64'h0);

        // Short then long frame
        do_reset();
        ok_base  = ok_cnt;
        err_base = err_cnt;
        run_frame(20);
        check("short_err_pulses", 64'(err_cnt - err_base), 64'd1);
        check("short_err_code", 64'(err_code), 64'h1);
        run_frame(50);
        check("long_err_pulses", 64'(err_cnt - err_base), 64'd2);
        check("long_err_code", 64'(err_code), 64'h2);
        check("long_frame_cnt", 64'(frame_cnt), 64'd2);
        check("long_seq", 64'(snapshot[47:40]), 64'h01);
        check("short_long_no_ok", 64'(ok_cnt - ok_base), 64'd0);

        // Timeout, then spi_clk ignored in abort
        err_base = err_cnt;
        cs_n = 1'b0;
        wait_clk(10);
        check("tmo_not_yet", 64'(err_cnt - err_base), 64'd0);
        check("tmo_busy_early", 64'(busy), 64'h1);
        wait_clk(15);
        check("tmo_err_pulse", 64'(err_cnt - err_base), 64'd1);
        check("tmo_err_code", 64'(err_code), 64'h3);
        check("tmo_busy_held", 64'(busy), 64'h1);
        sck_pulses(3);
        check("abort_sck_ignored", 64'(busy), 64'h1);
        cs_n = 1'b1;
        wait_clk(6);
        check("abort_no_extra_pulse", 64'(err_cnt - err_base), 64'd1);
        check("abort_busy_fall", 64'(busy), 64'h0);
        check("abort_err_code_held", 64'(err_code), 64'h3);

        // Update collision in the capture cycle
        cs_n = 1'b0;
        wait_clk(2);
        upd_valid = 1'b1;
        upd_data  = 40'h123456789A;
        wait_clk(1);
        upd_valid = 1'b0;
        check("bypass_data", 64'(snapshot[39:0]), 64'h123456789A);
        check("bypass_seq", 64'(snapshot[47:40]), 64'h03);
        held = snapshot;
        wait_clk(3);
        upd_valid = 1'b1;
        upd_data  = 40'hDEADBEEF01;
        wait_clk(1);
        upd_valid = 1'b0;
        check("active_upd_held", 64'(snapshot), 64'(held));
        sck_pulses(48);
        cs_n = 1'b1;
        wait_clk(6);
        check("post_frame_held", 64'(snapshot), 64'(held));
        check("collision_ok_code", 64'(err_code), 64'h0);
        run_frame(48);
        check("next_frame_new_live", 64'(snapshot[39:0]), 64'hDEADBEEF01);

        // Reset mid-frame with cs_n held low
        do_reset();
        cs_n = 1'b0;
        wait_clk(6);
        sck_pulses(10);
        reset = 1'b1;
        wait_clk(2);
        reset = 1'b0;
        ok_base  = ok_cnt;
        err_base = err_cnt;
        sck_pulses(38);
        cs_n = 1'b1;
        wait_clk(6);
        check("midrst_no_ok", 64'(ok_cnt - ok_base), 64'd0);
        check("midrst_no_err", 64'(err_cnt - err_base), 64'd0);
        check("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("midrst_snapshot", 64'(snapshot), 64'h0);
        check("midrst_busy", 64'(busy), 64'h0);
        run_frame(48);
        check("midrst_next_seq", 64'(snapshot[47:40]), 64'h00);
        check("midrst_next_cnt", 64'(frame_cnt), 64'd1);
        check("midrst_next_ok", 64'(ok_cnt - ok_base), 64'd1);

        // Sequence counter wrap
        do_reset();
        ok_base = ok_cnt;
        for (int i = 0; i < 255; i++) run_frame(48);
        check("wrap_cnt_255", 64'(frame_cnt), 64'd255);
        run_frame(48);
        check("wrap_seq_256", 64'(snapshot[47:40]), 64'hFF);
        check("wrap_cnt_0", 64'(frame_cnt), 64'd0);
        run_frame(48);
        check("wrap_seq_257", 64'(snapshot[47:40]), 64'h00);
        check("wrap_ok_pulses", 64'(ok_cnt - ok_base), 64'd257);

        check("ok_err_overlap", 64'(both_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
